branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Fetch-stage branch predictor that sits directly upstream of the hazard controller. On every cycle it looks up the current fetch PC in a direct-mapped table and reports whether the instruction is a known branch or jump, its predicted target and its predicted direction. These values travel with the instruction to decode, where the hazard controller compares them against the decoded truth. Decode feeds resolved branch information back so the table allocates entries, trains its counters and evicts entries for instructions that are not branches.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width of PCs and targets.
- INDEX_WIDTH, 6, table index bits; the table has 2^INDEX_WIDTH entries.
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-2, stored tag bits (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- fetch_pc  in  ADDR_WIDTH  PC being fetched this cycle.
- pred_hit  out  1  entry valid and tag matches; drives `valid_prediction`.
- pred_taken  out  1  predicted direction; drives `prediction`.
- pred_target  out  ADDR_WIDTH  stored target; drives `target_prediction`.
- pred_next_pc  out  ADDR_WIDTH  next fetch PC: pred_target if pred_taken, else fetch_pc+4.
- upd_valid  in  1  decode presents a resolved instruction this cycle.
- upd_pc  in  ADDR_WIDTH  PC of the resolved instruction.
- upd_is_branch  in  1  instruction is a conditional branch.
- upd_is_jump  in  1  instruction is an unconditional jump.
- upd_taken  in  1  resolved outcome; ignored when upd_is_jump is 1.
- upd_target  in  ADDR_WIDTH  resolved target.
- inv_all  in  1  synchronous invalidate of every entry.

## Operation
- Index is pc[INDEX_WIDTH+1:2]. Tag is pc[ADDR_WIDTH-1:INDEX_WIDTH+2]. pc[1:0] is ignored.
- Each entry holds: valid, tag, target, is_jump, and a 2-bit saturating counter (ctr).
- Lookup is purely combinational from fetch_pc.
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (is_jump | ctr[1]).
  - pred_target = the stored target on a hit, else 0.
- Update happens on the clock edge when upd_valid=1. Call the entry at upd_pc's index E.
- Branch or jump, E misses (invalid or tag mismatch): allocate E.
  - Set valid=1, tag, target=upd_target, is_jump=upd_is_jump.
  - Set ctr=10 if the instruction is a jump or is taken; otherwise ctr=01.
- Branch or jump, E hits: write target, is_jump, and ctr as follows.
  - Jump: ctr=11.
  - Taken branch: ctr saturating increment (11 stays 11).
  - Not-taken branch: ctr saturating decrement (00 stays 00).
- Neither branch nor jump, E hits (alias): clear E.valid.
- Neither branch nor jump, E misses: no change.
- upd_is_branch and upd_is_jump both 1: treat as a jump.
- inv_all clears every valid bit. It takes priority over a same-cycle update; that update is dropped.

## Timing
- Lookup latency is 0 cycles: outputs settle combinationally from fetch_pc and the current state.
- An update is visible to lookups from the cycle after the edge that writes it.
  - If upd_pc and fetch_pc share an index in the same cycle, the lookup returns the pre-update contents. There is no bypass.
- Reset (rst_n=0, asynchronous): all valid=0, all ctr=01, target/tag/is_jump=0.
  - Consequently, during and after reset: pred_hit=0, pred_taken=0, pred_target=0, pred_next_pc=fetch_pc+4.
- Deasserting rst_n mid-run discards all learned state. Updates presented while rst_n=0 are ignored.
- PC arithmetic is modulo 2^ADDR_WIDTH: fetch_pc=FFFFFFFC gives pred_next_pc=00000000.
- The block has no stall input. The fetch stage holds fetch_pc while stalled, and the outputs stay stable because they are combinational.

## Test plan
- Reset, then fetch_pc=00400010 → pred_hit=0, pred_taken=0, pred_next_pc=00400014.
- Update pc=00400010, branch, taken, target=00400040. Next cycle fetch 00400010 → hit=1, taken=1 (ctr=10), pred_next_pc=00400040. One not-taken update → ctr=01, taken=0, next_pc=00400014.
- Counter saturation: five taken updates → ctr=11. Then one not-taken → ctr=10, still taken. Three more not-taken → ctr=00. One further not-taken → ctr stays 00.
- Aliasing: allocate 00400010, then fetch 00401010 (same index 04, different tag) → hit=0. Update pc=00400010 as non-branch → the entry is invalidated, and fetch 00400010 → hit=0.
- Jump: update pc=00400100, jump, target=00400800 → ctr=10, taken=1. A second update with upd_taken=0 → ctr=11, still taken.
- Same-cycle events:
  - Update and lookup at the same index → old value returned that cycle, new value next cycle.
  - inv_all together with upd_valid → all entries invalid, update dropped.
  - rst_n pulsed low mid-run → pred_hit=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup and decode update signals of the branch target buffer
interface branch_target_buffer_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic                  pred_hit;
   logic                  pred_taken;
   logic [ADDR_WIDTH-1:0] pred_target;
   logic [ADDR_WIDTH-1:0] pred_next_pc;
   logic                  upd_valid;
   logic [ADDR_WIDTH-1:0] upd_pc;
   logic                  upd_is_branch;
   logic                  upd_is_jump;
   logic                  upd_taken;
   logic [ADDR_WIDTH-1:0] upd_target;
   logic                  inv_all;

   modport master (
      output fetch_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump,
             upd_taken, upd_target, inv_all,
      input  pred_hit, pred_taken, pred_target, pred_next_pc
   );

   modport slave (
      input  fetch_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump,
             upd_taken, upd_target, inv_all,
      output pred_hit, pred_taken, pred_target, pred_next_pc
   );
endinterface

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with 2-bit direction counters
module branch_target_buffer #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INDEX_WIDTH = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   branch_target_buffer_if.slave  bus
);
   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
   localparam int DEPTH     = 1 << INDEX_WIDTH;

   logic                  r_valid   [DEPTH];
   logic [TAG_WIDTH-1:0]  r_tag     [DEPTH];
   logic [ADDR_WIDTH-1:0] r_target  [DEPTH];
   logic                  r_is_jump [DEPTH];
   logic [1:0]            r_ctr     [DEPTH];

   logic [INDEX_WIDTH-1:0] w_fetch_idx;
   logic [TAG_WIDTH-1:0]   w_fetch_tag;
   logic                   w_fetch_hit;
   logic                   w_fetch_taken;
   logic [INDEX_WIDTH-1:0] w_upd_idx;
   logic [TAG_WIDTH-1:0]   w_upd_tag;
   logic                   w_upd_hit;
   logic                   w_upd_cf;
   logic                   w_upd_jump;
   logic [1:0]             w_cur_ctr;
   logic [1:0]             w_next_ctr;

   assign w_fetch_idx   = bus.fetch_pc[INDEX_WIDTH+1:2];
   assign w_fetch_tag   = bus.fetch_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign w_fetch_hit   = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
   assign w_fetch_taken = w_fetch_hit && (r_is_jump[w_fetch_idx] || r_ctr[w_fetch_idx][1]);

   assign bus.pred_hit     = w_fetch_hit;
   assign bus.pred_taken   = w_fetch_taken;
   assign bus.pred_target  = w_fetch_hit ? r_target[w_fetch_idx] : '0;
   assign bus.pred_next_pc = w_fetch_taken ? r_target[w_fetch_idx]
                                           : bus.fetch_pc + ADDR_WIDTH'(4);

   // A branch that is also flagged as a jump trains as a jump
   assign w_upd_idx  = bus.upd_pc[INDEX_WIDTH+1:2];
   assign w_upd_tag  = bus.upd_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign w_upd_hit  = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
   assign w_upd_jump = bus.upd_is_jump;
   assign w_upd_cf   = bus.upd_is_branch || bus.upd_is_jump;
   assign w_cur_ctr  = r_ctr[w_upd_idx];

   always_comb begin
      w_next_ctr = w_cur_ctr;
      if (!w_upd_hit) begin
         w_next_ctr = (w_upd_jump || bus.upd_taken) ? 2'b10 : 2'b01;
      end else if (w_upd_jump) begin
         w_next_ctr = 2'b11;
      end else if (bus.upd_taken) begin
         w_next_ctr = (w_cur_ctr == 2'b11) ? w_cur_ctr : w_cur_ctr + 2'b01;
      end else begin
         w_next_ctr = (w_cur_ctr == 2'b00) ? w_cur_ctr : w_cur_ctr - 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i]   <= 1'b0;
            r_tag[i]     <= '0;
            r_target[i]  <= '0;
            r_is_jump[i] <= 1'b0;
            r_ctr[i]     <= 2'b01;
         end
      end else if (bus.inv_all) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
         end
      end else if (bus.upd_valid) begin
         if (w_upd_cf) begin
            r_valid[w_upd_idx]   <= 1'b1;
            r_tag[w_upd_idx]     <= w_upd_tag;
            r_target[w_upd_idx]  <= bus.upd_target;
            r_is_jump[w_upd_idx] <= w_upd_jump;
            r_ctr[w_upd_idx]     <= w_next_ctr;
         end else if (w_upd_hit) begin
            // A non-branch that aliases onto a live entry evicts it
            r_valid[w_upd_idx] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - randomized and directed checks of branch_target_buffer against a table model
module tb_branch_target_buffer;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   branch_target_buffer_if #(.ADDR_WIDTH(32)) bus ();

   branch_target_buffer #(.ADDR_WIDTH(32), .INDEX_WIDTH(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bit        m_valid [64];
   bit [31:0] m_tag   [64];
   bit [31:0] m_target[64];
   bit        m_jump  [64];
   int        m_ctr   [64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_jump[i] = 0; m_ctr[i] = 1;
      end
   endtask

   task automatic model_lookup(input bit [31:0] pc, output bit hit, output bit taken,
                               output bit [31:0] tgt, output bit [31:0] nxt);
      int idx;
      idx   = (pc >> 2) % 64;
      hit   = m_valid[idx] && (m_tag[idx] == (pc >> 8));
      taken = hit && (m_jump[idx] || m_ctr[idx] >= 2);
      tgt   = hit ? m_target[idx] : 32'h0;
      nxt   = taken ? m_target[idx] : pc + 32'd4;
   endtask

   task automatic model_update(input bit uv, input bit [31:0] pc, input bit br, input bit jp,
                               input bit tk, input bit [31:0] tgt, input bit inv);
      int idx;
      bit hit;
      idx = (pc >> 2) % 64;
      hit = m_valid[idx] && (m_tag[idx] == (pc >> 8));
      if (inv) begin
         for (int i = 0; i < 64; i++) m_valid[i] = 0;
      end else if (uv) begin
         if (br || jp) begin
            if (!hit)       m_ctr[idx] = (jp || tk) ? 2 : 1;
            else if (jp)    m_ctr[idx] = 3;
            else if (tk)    m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
            else            m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
            m_valid[idx]  = 1;
            m_tag[idx]    = pc >> 8;
            m_target[idx] = tgt;
            m_jump[idx]   = jp;
         end else if (hit) begin
            m_valid[idx] = 0;
         end
      end
   endtask

   task automatic drive(input logic [31:0] f, input logic uv, input logic [31:0] upc, input logic br,
                        input logic jp, input logic tk, input logic [31:0] tgt, input logic inv);
      bus.fetch_pc = f;   bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_is_branch = br;
      bus.upd_is_jump = jp; bus.upd_taken = tk; bus.upd_target = tgt; bus.inv_all = inv;
   endtask

   task automatic check_lookup(input string tag);
      bit hit, taken;
      bit [31:0] tgt, nxt;
      model_lookup(bus.fetch_pc, hit, taken, tgt, nxt);
      check({tag, ".hit"},    32'(bus.pred_hit),   32'(hit));
      check({tag, ".taken"},  32'(bus.pred_taken), 32'(taken));
      check({tag, ".target"}, bus.pred_target,     tgt);
      check({tag, ".next"},   bus.pred_next_pc,    nxt);
   endtask

   // One clock: drive, compare pre-edge lookup with the model, clock, then advance the model
   task automatic cycle(input string tag, input logic [31:0] f, input logic uv, input logic [31:0] upc,
                        input logic br, input logic jp, input logic tk, input logic [31:0] tgt,
                        input logic inv);
      drive(f, uv, upc, br, jp, tk, tgt, inv);
      #3;
      check_lookup(tag);
      @(posedge clk);
      model_update(uv, upc, br, jp, tk, tgt, inv);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic br, input logic jp, input logic tk,
                      input logic [31:0] tgt);
      cycle("upd", pc, 1'b1, pc, br, jp, tk, tgt, 1'b0);
   endtask

   task automatic look(input logic [31:0] f);
      drive(f, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] tags [3];
      tags[0] = 32'h00004004; tags[1] = 32'h00004010; tags[2] = 32'h00FFFFFF;
      return (tags[$urandom_range(0, 2)] << 8) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      model_reset();
      drive(32'h00400010, 1'b1, 32'h00400010, 1'b1, 1'b0, 1'b1, 32'h00400040, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      look(32'h00400010);
      check("reset.hit",   32'(bus.pred_hit),   32'h0);
      check("reset.taken", 32'(bus.pred_taken), 32'h0);
      check("reset.tgt",   bus.pred_target,     32'h0);
      check("reset.next",  bus.pred_next_pc,    32'h00400014);

      upd(32'h00400010, 1'b1, 1'b0, 1'b1, 32'h00400040);
      look(32'h00400010);
      check("alloc.hit",  32'(bus.pred_hit),   32'h1);
      check("alloc.taken", 32'(bus.pred_taken), 32'h1);
      check("alloc.next", bus.pred_next_pc,    32'h00400040);
      upd(32'h00400010, 1'b1, 1'b0, 1'b0, 32'h00400040);
      look(32'h00400010);
      check("nt1.taken", 32'(bus.pred_taken), 32'h0);
      check("nt1.next",  bus.pred_next_pc,    32'h00400014);

      repeat (5) upd(32'h00400010, 1'b1, 1'b0, 1'b1, 32'h00400040);
      upd(32'h00400010, 1'b1, 1'b0, 1'b0, 32'h00400040);
      look(32'h00400010);
      check("sat_hi.taken", 32'(bus.pred_taken), 32'h1);
      repeat (4) upd(32'h00400010, 1'b1, 1'b0, 1'b0, 32'h00400040);
      upd(32'h00400010, 1'b1, 1'b0, 1'b1, 32'h00400040);
      look(32'h00400010);
      check("sat_lo.taken", 32'(bus.pred_taken), 32'h0);

      look(32'h00401010);
      check("alias.hit", 32'(bus.pred_hit), 32'h0);
      upd(32'h00400010, 1'b0, 1'b0, 1'b0, 32'h0);
      look(32'h00400010);
      check("evict.hit", 32'(bus.pred_hit), 32'h0);

      upd(32'h00400100, 1'b0, 1'b1, 1'b0, 32'h00400800);
      look(32'h00400100);
      check("jump.taken", 32'(bus.pred_taken), 32'h1);
      check("jump.next",  bus.pred_next_pc,    32'h00400800);
      upd(32'h00400100, 1'b0, 1'b1, 1'b0, 32'h00400800);
      upd(32'h00400100, 1'b1, 1'b0, 1'b0, 32'h00400800);
      look(32'h00400100);
      check("jump_ctr11.taken", 32'(bus.pred_taken), 32'h1);
      upd(32'h00400100, 1'b1, 1'b0, 1'b0, 32'h00400800);
      look(32'h00400100);
      check("jump_ctr01.taken", 32'(bus.pred_taken), 32'h0);

      drive(32'h00400200, 1'b1, 32'h00400200, 1'b1, 1'b0, 1'b1, 32'h00400900, 1'b0);
      #3;
      check("bypass.old_hit", 32'(bus.pred_hit), 32'h0);
      @(posedge clk);
      model_update(1'b1, 32'h00400200, 1'b1, 1'b0, 1'b1, 32'h00400900, 1'b0);
      #1;
      look(32'h00400200);
      check("bypass.new_hit", 32'(bus.pred_hit), 32'h1);

      cycle("inv", 32'h00400200, 1'b1, 32'h00400300, 1'b1, 1'b0, 1'b1, 32'h00400a00, 1'b1);
      look(32'h00400200);
      check("inv.old_hit", 32'(bus.pred_hit), 32'h0);
      look(32'h00400300);
      check("inv.drop_hit", 32'(bus.pred_hit), 32'h0);

      upd(32'h00400400, 1'b0, 1'b1, 1'b0, 32'h00400c00);
      look(32'h00400400);
      check("prerst.hit", 32'(bus.pred_hit), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("asyncrst.hit",  32'(bus.pred_hit),  32'h0);
      check("asyncrst.next", bus.pred_next_pc,   32'h00400404);
      model_reset();
      drive(32'h00400500, 1'b1, 32'h00400500, 1'b0, 1'b1, 1'b0, 32'h00400d00, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      look(32'h00400500);
      check("rstupd.hit", 32'(bus.pred_hit), 32'h0);

      look(32'hFFFFFFFC);
      check("wrap.next", bus.pred_next_pc, 32'h00000000);

      for (int n = 0; n < 1500; n++) begin
         logic [31:0] f, upc;
         int kind;
         f    = rand_pc();
         upc  = ($urandom_range(0, 3) == 0) ? f : rand_pc();
         kind = $urandom_range(0, 3);
         cycle("rand", f, $urandom_range(0, 3) != 0, upc, kind == 1 || kind == 3,
               kind == 2 || kind == 3, 1'($urandom), $urandom, $urandom_range(0, 99) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
